// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each grant takes three cycles: IDLE (arbitrate) -> ACCESS (drive memory) -> RESP (ack).
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            rw,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out,
  output logic                  mem_read_write,
  output logic                  mem_chip_en
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                winner_q, winner_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                mem_read_write_q, mem_read_write_d;
  logic                mem_chip_en_q, mem_chip_en_d;
  logic                win;

  // A lone requester always wins; on contention the one not served last wins.
  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    if (r == 2'b11) begin
      return ~last;
    end
    return r[0] ? 1'b0 : 1'b1;
  endfunction

  // The mem_* registers double as the latched copy of the winner's request,
  // so nothing after IDLE looks at the live request inputs again.
  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    winner_d         = winner_q;
    ack_d            = 2'b00;
    rdata_d          = rdata_q;
    busy_d           = 1'b0;
    mem_address_d    = '0;
    mem_data_in_d    = '0;
    mem_read_write_d = 1'b0;
    mem_chip_en_d    = 1'b0;
    win              = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          win              = pick_winner(req, last_q);
          winner_d         = win;
          state_d          = ACCESS;
          busy_d           = 1'b1;
          mem_chip_en_d    = 1'b1;
          mem_read_write_d = rw[win];
          mem_address_d    = win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          if (rw[win]) begin
            mem_data_in_d = win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        busy_d  = 1'b1;
        ack_d   = winner_q ? 2'b10 : 2'b01;
        if (!mem_read_write_q) begin
          rdata_d = mem_data_out;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = winner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      last_q           <= 1'b1;
      winner_q         <= 1'b0;
      ack_q            <= 2'b00;
      rdata_q          <= '0;
      busy_q           <= 1'b0;
      mem_address_q    <= '0;
      mem_data_in_q    <= '0;
      mem_read_write_q <= 1'b0;
      mem_chip_en_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_q           <= last_d;
      winner_q         <= winner_d;
      ack_q            <= ack_d;
      rdata_q          <= rdata_d;
      busy_q           <= busy_d;
      mem_address_q    <= mem_address_d;
      mem_data_in_q    <= mem_data_in_d;
      mem_read_write_q <= mem_read_write_d;
      mem_chip_en_q    <= mem_chip_en_d;
    end
  end

  assign ack            = ack_q;
  assign rdata          = rdata_q;
  assign busy           = busy_q;
  assign mem_address    = mem_address_q;
  assign mem_data_in    = mem_data_in_q;
  assign mem_read_write = mem_read_write_q;
  assign mem_chip_en    = mem_chip_en_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 8: memory address width.
REQ-002 SHALL take parameter DATA_W, default 8: memory data width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 2: req[i] high = requester i has a pending transaction.
REQ-006 SHALL have port rw, input, 2: rw[i] = 1 write, 0 read, for requester i.
REQ-007 SHALL have port addr, input, 2*ADDR_W: addr[i*ADDR_W +: ADDR_W] = address of requester i.
REQ-008 SHALL have port wdata, input, 2*DATA_W: wdata[i*DATA_W +: DATA_W] = write data of requester i.
REQ-009 SHALL have port ack, output, 2: one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata, output, DATA_W: read data, valid only in the ack cycle of a read.
REQ-011 SHALL have port busy, output, 1: high while a transaction is in ACCESS or RESP.
REQ-012 SHALL have port mem_address, output, ADDR_W: drives memory address.
REQ-013 SHALL have port mem_data_in, output, DATA_W: drives memory write data.
REQ-014 SHALL have port mem_data_out, input, DATA_W: memory read data, combinational from memory.
REQ-015 SHALL have port mem_read_write, output, 1: 1 = write, 0 = read.
REQ-016 SHALL have port mem_chip_en, output, 1: memory enable, active high.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-018 SHALL register every output; no output combinationally depends on any input.
REQ-019 In IDLE with any req bit high, the FSM SHALL select a winner, latch its rw/addr/wdata and winner index, and go to ACCESS.
REQ-020 SHALL select the winner round-robin: with a single requester, that requester wins; with both requesters, the one not served last wins.
REQ-021 In ACCESS, the block SHALL drive mem_chip_en=1, mem_read_write=latched rw, mem_address=latched addr and mem_data_in=latched wdata (0 for reads), for exactly one cycle.
REQ-022 At the end of ACCESS for a read, the block SHALL capture mem_data_out into rdata, then go to RESP.
REQ-023 In RESP, the block SHALL pulse ack[winner]=1 for one cycle, update the last-served pointer to the winner, and go to IDLE.
REQ-024 Latency SHALL be: req sampled high at edge N -> mem_chip_en high in cycle N..N+1 -> ack high in cycle N+1..N+2; total 3 cycles per transaction, back-to-back throughput one transaction per 3 cycles.
REQ-025 Requesters SHALL hold req/rw/addr/wdata stable until ack; the block itself uses only latched copies after IDLE.
REQ-026 A req still high in the cycle after ack SHALL be treated as a new transaction.
REQ-027 If req drops during ACCESS or RESP, the transaction SHALL complete and ack SHALL still be issued.
REQ-028 Outside ACCESS, the block SHALL hold mem_chip_en=0, mem_read_write=0, mem_address=0 and mem_data_in=0.
REQ-029 rdata SHALL hold its last captured value outside RESP, and SHALL not be updated by writes.
REQ-030 busy SHALL be 1 in ACCESS and RESP and 0 in IDLE.
REQ-031 At most one ack bit SHALL be high in any cycle.

Reset
REQ-032 While reset is high at a clock edge, the block SHALL enter IDLE and set ack=0, rdata=0, busy=0, all mem_* outputs to 0, and last-served to 1, so requester 0 wins first.
REQ-033 Reset asserted in ACCESS or RESP SHALL abort the transaction with no ack issued; the first post-reset arbitration SHALL follow REQ-032.

Verification
REQ-034 Single write: req=01, rw=01, addr0=0x10, wdata0=0xA5 -> one cycle with mem_chip_en=1, mem_read_write=1, mem_address=0x10, mem_data_in=0xA5; ack=01 two cycles after sampling.
REQ-035 Readback: after REQ-034, requester 1 reads 0x10 -> mem_read_write=0 in ACCESS; ack=10 with rdata=0xA5.
REQ-036 Contention: req=11 held continuously after reset -> grants alternate 0,1,0,1; ack pulses every 3 cycles; no double ack.
REQ-037 Drop mid-access: req0 deasserted in the ACCESS cycle -> ack0 still pulses; the next arbitration sees only the remaining requests.
REQ-038 Reset mid-op: reset asserted in the ACCESS cycle -> next cycle mem_chip_en=0, ack=00, busy=0; with req=11 afterwards, requester 0 wins.
REQ-039 Idle quiescence: req=00 for 20 cycles -> mem_chip_en, ack and busy stay 0; rdata stays unchanged.
